qubo_energy_eval: RTL and testbench

QUBO_ENERGY_EVAL -- requirements
Module: qubo_energy_eval

---
 rtl/qubo_energy_eval.sv | 131 +++++++++++++
 tb/tb_qubo_energy_eval.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qubo_energy_eval.sv
// QUBO energy evaluator: computes s^T Q s for a binary candidate one row per cycle
// and tracks the lowest energy seen since reset or clear_best.
module qubo_energy_eval #(
  parameter int N  = 4,
  parameter int EW = $clog2(N*N+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0][N-1:0] Q,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N-1:0]        s,
  output logic                e_valid,
  input  logic                e_ready,
  output logic [EW-1:0]       energy,
  output logic [N-1:0]        e_state,
  output logic [EW-1:0]       best_energy,
  output logic [N-1:0]        best_s,
  input  logic                clear_best
);

  localparam int RW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic          s_ready_nx_s;
  logic          e_valid_nx_s;
  logic [N-1:0]  s_lat_r;
  logic [RW-1:0] row_r;
  logic [EW-1:0] acc_r;
  logic [EW-1:0] term_s;
  logic [EW-1:0] best_ref_s;
  logic          accum_s;
  logic          finish_s;

  // Contribution of one row: popcount(q_row & sv) when the row's own bit is set.
  function automatic logic [EW-1:0] row_term(input logic [N-1:0] q_row,
                                             input logic [N-1:0] sv,
                                             input logic         sel);
    logic [EW-1:0] cnt;
    cnt = {EW{1'b0}};
    for (int k = 0; k < N; k++) begin
      cnt = cnt + EW'(q_row[k] & sv[k]);
    end
    return sel ? cnt : {EW{1'b0}};
  endfunction

  // ACCUM spends N cycles adding rows, then one finishing cycle (row_r == N) loads the result.
  assign accum_s    = (state_r == ACCUM) && (row_r != RW'(N));
  assign finish_s   = (state_r == ACCUM) && (row_r == RW'(N));
  assign best_ref_s = clear_best ? {EW{1'b1}} : best_energy;

  // Row term for the current row index; only one row matches so OR-ing is safe.
  always_comb begin
    term_s = {EW{1'b0}};
    for (int i = 0; i < N; i++) begin
      term_s = term_s | ((row_r == RW'(i)) ? row_term(Q[i], s_lat_r, s_lat_r[i]) : {EW{1'b0}});
    end
  end

  // State register and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      s_ready <= 1'b1;
      e_valid <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      s_ready <= s_ready_nx_s;
      e_valid <= e_valid_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = s_valid ? ACCUM : IDLE;
      ACCUM:   state_nx_s = finish_s ? DONE : ACCUM;
      DONE:    state_nx_s = e_ready ? IDLE : DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they register alongside it.
  always_comb begin
    s_ready_nx_s = (state_nx_s == IDLE);
    e_valid_nx_s = (state_nx_s == DONE);
  end

  // Datapath: candidate latch, accumulator, result and best-so-far registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_lat_r     <= {N{1'b0}};
      row_r       <= {RW{1'b0}};
      acc_r       <= {EW{1'b0}};
      energy      <= {EW{1'b0}};
      e_state     <= {N{1'b0}};
      best_energy <= {EW{1'b1}};
      best_s      <= {N{1'b0}};
    end else begin
      if ((state_r == IDLE) && s_valid) begin
        s_lat_r <= s;
        acc_r   <= {EW{1'b0}};
        row_r   <= {RW{1'b0}};
      end else if (accum_s) begin
        acc_r <= acc_r + term_s;
        row_r <= row_r + RW'(1);
      end
      if (finish_s) begin
        energy  <= acc_r;
        e_state <= s_lat_r;
      end
      // A coincident clear acts first, so the new result always wins over the cleared value.
      if (finish_s && (acc_r < best_ref_s)) begin
        best_energy <= acc_r;
        best_s      <= s_lat_r;
      end else if (clear_best) begin
        best_energy <= {EW{1'b1}};
        best_s      <= {N{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_qubo_energy_eval.sv
// Scoreboard bench for qubo_energy_eval: a driver pushes expected results computed
// from the double-sum definition of s^T Q s; a monitor pops them on each result handshake.
module tb_qubo_energy_eval;
  localparam int N  = 4;
  localparam int EW = $clog2(N*N+1);
  localparam int ONES = (1 << EW) - 1;

  logic                clk = 1'b0;
  logic                rst, s_valid, s_ready, e_valid, e_ready, clear_best;
  logic [N-1:0][N-1:0] Q;
  logic [N-1:0]        s, e_state, best_s;
  logic [EW-1:0]       energy, best_energy;

  int checks = 0;
  int failures = 0;
  bit ready_low = 1'b0;
  bit ready_rand = 1'b1;

  typedef struct {
    int e;
    int st;
    int be;
    int bs;
  } exp_t;
  exp_t sb[$];
  int m_best;
  int m_best_s;

  always #5 clk = ~clk;

  qubo_energy_eval #(.N(N), .EW(EW)) dut (
    .clk(clk), .rst(rst), .Q(Q), .s_valid(s_valid), .s_ready(s_ready), .s(s),
    .e_valid(e_valid), .e_ready(e_ready), .energy(energy), .e_state(e_state),
    .best_energy(best_energy), .best_s(best_s), .clear_best(clear_best)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_energy(input logic [N-1:0][N-1:0] q, input logic [N-1:0] v);
    int e;
    e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        e += (q[i][j] && v[i] && v[j]) ? 1 : 0;
    return e;
  endfunction

  // Consumer ready: random, forced low, or forced high; changes well after the edge.
  initial begin
    e_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      e_ready = ready_low ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: compare on every accepted result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && e_valid && e_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          x = sb.pop_front();
          check("energy", int'(energy), x.e);
          check("e_state", int'(e_state), x.st);
          check("best_energy", int'(best_energy), x.be);
          check("best_s", int'(best_s), x.bs);
        end
      end
    end
  end

  task automatic present(input logic [N-1:0] sv, output bit ok);
    int n;
    @(negedge clk);
    s = sv;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic eval(input logic [N-1:0] sv, input bit clr_fin, input bit check_lat);
    bit ok;
    int e;
    exp_t x;
    present(sv, ok);
    if (ok) begin
      e = ref_energy(Q, sv);
      if (clr_fin) begin
        m_best = ONES;
        m_best_s = 0;
      end
      if (e < m_best) begin
        m_best = e;
        m_best_s = int'(sv);
      end
      x.e = e; x.st = int'(sv); x.be = m_best; x.bs = m_best_s;
      sb.push_back(x);
      // Accept edge already passed (we are 1 time unit after it).
      for (int k = 1; k <= N + 1; k++) begin
        if (clr_fin && k == N + 1) clear_best = 1'b1;
        @(posedge clk);
        #1 clear_best = 1'b0;
        if (check_lat) begin
          check("lat_e_valid", int'(e_valid), (k == N + 1) ? 1 : 0);
          if (k <= N) check("busy_s_ready", int'(s_ready), 0);
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || e_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drained", (n < 300) ? 1 : 0, 1);
  endtask

  initial begin
    int held_e, held_st, n;
    logic [N-1:0] rs;
    bit ok;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rs;
    bit ok;
    int held_e, held_st;
    rst = 1'b1; s_valid = 1'b0; clear_best = 1'b0; s = '0; Q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_e_valid", int'(e_valid), 0);
    check("rst_energy", int'(energy), 0);
    check("rst_e_state", int'(e_state), 0);
    check("rst_best_energy", int'(best_energy), ONES);
    check("rst_best_s", int'(best_s), 0);
    rst = 1'b0;
    m_best = ONES;
    m_best_s = 0;

    // Identity matrix: energy is the number of set bits.
    for (int i = 0; i < N; i++) begin Q[i] = '0; Q[i][i] = 1'b1; end
    eval(4'b1011, 1'b0, 1'b1);
    // All-ones matrix, then a tie pair under identity.
    Q = '1;
    eval(4'b1111, 1'b0, 1'b1);
    eval(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin Q[i] = '0; Q[i][i] = 1'b1; end
    eval(4'b0100, 1'b0, 1'b0);
    drain();

    // Consumer stalls for 10 cycles in DONE.
    ready_low = 1'b1;
    Q = '1;
    eval(4'b0110, 1'b0, 1'b1);
    held_e = int'(energy);
    held_st = int'(e_state);
    check("hold_energy_value", held_e, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_e_valid", int'(e_valid), 1);
      check("hold_s_ready", int'(s_ready), 0);
      check("hold_energy", int'(energy), held_e);
      check("hold_e_state", int'(e_state), held_st);
    end
    ready_rand = 1'b0;
    ready_low = 1'b0;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    check("release_s_ready", int'(s_ready), 1);
    check("release_e_valid", int'(e_valid), 0);
    check("after_hs_energy", int'(energy), held_e);
    ready_rand = 1'b1;

    // Clear coinciding with a result of energy 7.
    Q = '0; Q[0] = 4'b1111; Q[1] = 4'b0111;
    eval(4'b1111, 1'b1, 1'b1);
    drain();
    @(negedge clk);
    check("best_after_clr_fin", int'(best_energy), 7);
    clear_best = 1'b1;
    @(posedge clk);
    #1 clear_best = 1'b0;
    m_best = ONES;
    m_best_s = 0;
    check("clear_best_energy", int'(best_energy), ONES);
    check("clear_best_s", int'(best_s), 0);

    // Reset in the middle of ACCUM (row 2) aborts the evaluation.
    Q = '1;
    eval(4'b0001, 1'b0, 1'b0);
    drain();
    present(4'b1110, ok);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_best = ONES;
    m_best_s = 0;
    check("abort_s_ready", int'(s_ready), 1);
    check("abort_e_valid", int'(e_valid), 0);
    check("abort_best_energy", int'(best_energy), ONES);
    check("abort_best_s", int'(best_s), 0);
    eval(4'b1110, 1'b0, 1'b1);

    // Randomized candidates and matrices.
    for (int t = 0; t < 40; t++) begin
      Q = N*N'($urandom);
      rs = N'($urandom);
      eval(rs, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
